// File: rtl/instruction_fetch_bridge.sv
// Instruction fetch bridge: turns the fetch PC into single-outstanding bus requests
// and serves fetch from a one-entry tagged holding register.
module instruction_fetch_bridge #(
   parameter int unsigned TIMEOUT_CYCLES  = 255,
   parameter logic [31:0] NOP_INSTRUCTION = 32'h00000013
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] instructionAddress,
   input  logic        flush,
   output logic [31:0] instructionData,
   output logic        instructionDataValid,
   output logic        instructionAccessFault,
   output logic        instructionAddressMisaligned,
   output logic        busRequestValid,
   input  logic        busRequestReady,
   output logic [31:0] busRequestAddress,
   input  logic        busResponseValid,
   input  logic [31:0] busResponseData,
   input  logic        busResponseError
);

   typedef enum logic [1:0] {IDLE, REQUEST, WAIT} state_t;

   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state_q;
   logic        req_valid_q;
   logic [31:0] req_addr_q;
   logic [15:0] cnt_q;
   logic        hold_valid_q;
   logic        hold_fault_q;
   logic [31:0] hold_tag_q;
   logic [31:0] hold_data_q;
   logic        stale_q;
   logic        orphan_q;

   logic hit;
   logic aligned;
   logic accepted;
   logic deliverable;
   logic resp_live;
   logic timed_out;

   assign aligned     = (instructionAddress[1:0] == 2'b00);
   assign hit         = hold_valid_q && (hold_tag_q == instructionAddress) && !flush;
   assign accepted    = req_valid_q && busRequestReady;
   // The registered request address doubles as the pending tag.
   assign deliverable = !stale_q && !flush && (req_addr_q == instructionAddress);
   assign resp_live   = busResponseValid && !orphan_q;
   assign timed_out   = (cnt_q == TIMEOUT_LAST);

   assign instructionData              = hold_fault_q ? NOP_INSTRUCTION : hold_data_q;
   assign instructionDataValid         = hit;
   assign instructionAccessFault       = hit && hold_fault_q;
   assign instructionAddressMisaligned = !aligned;
   assign busRequestValid              = req_valid_q;
   assign busRequestAddress            = req_addr_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         req_valid_q  <= 1'b0;
         req_addr_q   <= '0;
         cnt_q        <= '0;
         hold_valid_q <= 1'b0;
         hold_fault_q <= 1'b0;
         hold_tag_q   <= '0;
         hold_data_q  <= '0;
         stale_q      <= 1'b0;
         orphan_q     <= 1'b0;
      end else begin
         if (flush) hold_valid_q <= 1'b0;
         // A response after a timeout belongs to the abandoned access; swallow it.
         if (busResponseValid && orphan_q) orphan_q <= 1'b0;

         case (state_q)
            IDLE: begin
               if (!hit && aligned && !flush) begin
                  req_valid_q <= 1'b1;
                  req_addr_q  <= {instructionAddress[31:2], 2'b00};
                  state_q     <= REQUEST;
               end
            end
            REQUEST: begin
               if (flush) stale_q <= 1'b1;
               if (accepted) begin
                  req_valid_q <= 1'b0;
                  cnt_q       <= '0;
                  state_q     <= WAIT;
               end
            end
            WAIT: begin
               if (resp_live) begin
                  if (deliverable) begin
                     hold_valid_q <= 1'b1;
                     hold_fault_q <= busResponseError;
                     hold_data_q  <= busResponseData;
                     hold_tag_q   <= req_addr_q;
                  end
                  stale_q <= 1'b0;
                  state_q <= IDLE;
               end else if (timed_out) begin
                  if (deliverable) begin
                     hold_valid_q <= 1'b1;
                     hold_fault_q <= 1'b1;
                     hold_tag_q   <= req_addr_q;
                  end
                  stale_q  <= 1'b0;
                  orphan_q <= 1'b1;
                  state_q  <= IDLE;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
                  if (flush) stale_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
